gpio_port: RTL and testbench

- Parametrised GPIO peripheral; the successor to the fixed 8-bit gpio pins on the top-level board.
- Provides a configurable pin count, per-pin direction, and 2-FF input synchronisation.
- Adds per-pin rising/falling edge interrupts with sticky write-1-to-clear status, plus an atomic toggle register.
- Sits on the CPU peripheral bus. Tristate pads are built at top level from gpio_o/gpio_oe.

---
 rtl/gpio_port_if.sv | 13 +
 rtl/gpio_port.sv | 131 +++++++++++++
 tb/tb_gpio_port.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_port_if.sv
// Peripheral bus bundle for gpio_port: register select, write/read strobes and data.
interface gpio_port_if #(
  parameter int unsigned WIDTH = 8
);
  logic [2:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/gpio_port.sv
// Parametrised GPIO: per-pin direction, synchronised inputs, sticky W1C edge interrupts
// and an atomic toggle register on the CPU peripheral bus.
module gpio_port #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_DIR     = 3'd1,
    REG_IN      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5,
    REG_TOGGLE  = 3'd6,
    REG_RSVD    = 3'd7
  } reg_addr_e;

  localparam int unsigned ARM_COUNT = SYNC_STAGES + 1;
  localparam int unsigned ARM_W     = $clog2(ARM_COUNT + 1);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [ARM_W-1:0] r_arm_cnt;

  reg_addr_e        w_addr;
  logic [WIDTH-1:0] w_sync;
  logic             w_armed;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rd_mux;

  assign w_addr  = reg_addr_e'(bus.addr);
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_armed = (r_arm_cnt == ARM_W'(ARM_COUNT));

  // Events are ignored until the synchroniser and prev register hold real pin data,
  // so pins already high at reset release do not look like rising edges.
  always_comb begin
    w_event = '0;
    if (w_armed) begin
      w_event = (w_sync & ~r_prev & r_rise_en) | (~w_sync & r_prev & r_fall_en);
    end
  end

  always_comb begin
    w_w1c = '0;
    if (bus.we && (w_addr == REG_STATUS)) begin
      w_w1c = bus.wdata;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      REG_OUT:     w_rd_mux = r_out;
      REG_DIR:     w_rd_mux = r_dir;
      REG_IN:      w_rd_mux = w_sync;
      REG_RISE_EN: w_rd_mux = r_rise_en;
      REG_FALL_EN: w_rd_mux = r_fall_en;
      REG_STATUS:  w_rd_mux = r_status;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
      r_rdata   <= '0;
      r_prev    <= '0;
      r_arm_cnt <= '0;
    end else begin
      if (bus.we) begin
        case (w_addr)
          REG_OUT:     r_out     <= bus.wdata;
          REG_DIR:     r_dir     <= bus.wdata;
          REG_RISE_EN: r_rise_en <= bus.wdata;
          REG_FALL_EN: r_fall_en <= bus.wdata;
          REG_TOGGLE:  r_out     <= r_out ^ bus.wdata;
          default:     ;
        endcase
      end
      // New events are OR-ed in after the clear so a same-cycle set survives its W1C.
      r_status <= (r_status & ~w_w1c) | w_event;
      r_prev   <= w_sync;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
      if (bus.re) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign bus.rdata = r_rdata;
  assign gpio_o    = r_out;
  assign gpio_oe   = r_dir;
  assign irq       = |r_status;

endmodule

// File: tb/tb_gpio_port.sv
// Directed plus randomised bench for gpio_port, checked against a rule-level model
// that tracks register contents, pin history and edges elapsed since reset.
module tb_gpio_port;

  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 2;

  logic         clk = 1'b0;
  logic         t_rst = 1'b0;
  logic [2:0]   t_addr = '0;
  logic [W-1:0] t_wdata = '0;
  logic         t_we = 1'b0;
  logic         t_re = 1'b0;
  logic [W-1:0] t_gpio = '0;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_port_if #(.WIDTH(W)) bus ();

  assign bus.addr  = t_addr;
  assign bus.wdata = t_wdata;
  assign bus.we    = t_we;
  assign bus.re    = t_re;

  gpio_port #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (t_rst),
    .bus     (bus),
    .gpio_i  (t_gpio),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status, m_rdata, m_sync, m_prev;
  logic [W-1:0] m_pins [$];
  int unsigned  m_edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0;
    m_status = '0; m_rdata = '0; m_sync = '0; m_prev = '0;
    m_edges = 0;
    m_pins = {};
    for (int i = 0; i < int'(SYNC) - 1; i++) m_pins.push_back('0);
  endtask

  task automatic tick();
    logic [W-1:0] rv, ev, w1c;
    @(posedge clk);
    if (!t_rst) begin
      model_reset();
    end else begin
      case (t_addr)
        3'd0: rv = m_out;
        3'd1: rv = m_dir;
        3'd2: rv = m_sync;
        3'd3: rv = m_rise;
        3'd4: rv = m_fall;
        3'd5: rv = m_status;
        default: rv = '0;
      endcase
      if (t_re) m_rdata = rv;
      ev = '0;
      if (m_edges >= SYNC + 1)
        ev = (m_sync & ~m_prev & m_rise) | (~m_sync & m_prev & m_fall);
      w1c = (t_we && t_addr == 3'd5) ? t_wdata : '0;
      m_status = (m_status & ~w1c) | ev;
      if (t_we) begin
        case (t_addr)
          3'd0: m_out  = t_wdata;
          3'd1: m_dir  = t_wdata;
          3'd3: m_rise = t_wdata;
          3'd4: m_fall = t_wdata;
          3'd6: m_out  = m_out ^ t_wdata;
          default: ;
        endcase
      end
      m_pins.push_back(t_gpio);
      m_prev = m_sync;
      m_sync = m_pins.pop_front();
      if (m_edges < 1000) m_edges++;
    end
    #1;
    check("gpio_o", 32'(gpio_o), 32'(m_out));
    check("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    check("irq", 32'(irq), 32'(|m_status));
    check("rdata", 32'(bus.rdata), 32'(m_rdata));
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    t_addr = a; t_wdata = d; t_we = 1'b1;
    tick();
    t_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
    t_addr = a; t_re = 1'b1;
    tick();
    t_re = 1'b0;
    check(tag, 32'(bus.rdata), 32'(exp));
  endtask

  initial begin
    model_reset();
    // Reset values
    t_rst = 1'b0;
    repeat (3) tick();
    t_rst = 1'b1;
    check("rst_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 8; a++) rd($sformatf("rst_rd%0d", a), 3'(a), 8'h00);

    // Output path and toggle
    wr(3'd1, 8'hF0);
    check("dir_oe", 32'(gpio_oe), 32'hF0);
    wr(3'd0, 8'hA5);
    check("out_o", 32'(gpio_o), 32'hA5);
    wr(3'd6, 8'h0F);
    check("toggle_o", 32'(gpio_o), 32'hAA);
    rd("rd_out", 3'd0, 8'hAA);
    rd("rd_toggle", 3'd6, 8'h00);

    // Synchroniser latency
    t_gpio = 8'h3C; t_addr = 3'd2; t_re = 1'b1;
    tick(); check("sync_n",  32'(bus.rdata), 32'h00);
    tick(); check("sync_n1", 32'(bus.rdata), 32'h00);
    tick(); check("sync_n2", 32'(bus.rdata), 32'h3C);
    t_re = 1'b0;

    // Rising interrupt on pin0
    wr(3'd3, 8'h01);
    t_gpio = 8'h3D;
    tick(); check("rise_e1", 32'(irq), 32'h0);
    tick(); check("rise_e2", 32'(irq), 32'h0);
    tick(); check("rise_e3", 32'(irq), 32'h1);
    rd("rise_status", 3'd5, 8'h01);
    wr(3'd5, 8'h01);
    check("w1c_irq", 32'(irq), 32'h0);
    t_gpio = 8'h3C;
    repeat (5) tick();
    check("fall_masked_irq", 32'(irq), 32'h0);
    rd("fall_masked_st", 3'd5, 8'h00);

    // Set/clear collision on pin7
    wr(3'd4, 8'h80);
    t_gpio = 8'hBC; repeat (4) tick();
    t_gpio = 8'h3C; repeat (4) tick();
    check("coll_pre_irq", 32'(irq), 32'h1);
    t_gpio = 8'hBC; repeat (4) tick();
    t_gpio = 8'h3C;
    tick(); tick();
    wr(3'd5, 8'h80);
    check("coll_irq", 32'(irq), 32'h1);
    rd("coll_status", 3'd5, 8'h80);
    wr(3'd5, 8'h80);
    check("coll_clr_irq", 32'(irq), 32'h0);

    // Mid-operation reset with pending read, then arming with pins high
    t_gpio = 8'hFF; t_addr = 3'd0; t_re = 1'b1; t_rst = 1'b0;
    tick();
    check("rst_pending_rd", 32'(bus.rdata), 32'h00);
    t_re = 1'b0;
    repeat (2) tick();
    t_rst = 1'b1;
    wr(3'd3, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("arm_irq", 32'(irq), 32'h0);
    end
    rd("arm_status", 3'd5, 8'h00);
    t_gpio = 8'hF7; repeat (5) tick();
    t_gpio = 8'hFF; repeat (4) tick();
    rd("arm_pin3", 3'd5, 8'h08);

    // Randomised traffic against the model
    wr(3'd4, 8'h5A);
    for (int i = 0; i < 400; i++) begin
      t_addr  = 3'($urandom_range(0, 7));
      t_wdata = W'($urandom);
      t_we    = ($urandom_range(0, 3) == 0);
      t_re    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) t_gpio = W'($urandom);
      t_rst   = ($urandom_range(0, 99) != 0);
      tick();
    end
    t_we = 1'b0; t_re = 1'b0; t_rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
